yarvi_fq: RTL and testbench
===========================

Name: yarvi_fq

Overview:
- Fetch queue and predecode stage placed directly downstream of the fetch stage, yarvi_fe, and upstream of decode/execute.
- Accepts {pc, insn} pairs from fetch with a valid/ready handshake.
- Predecodes each instruction at enqueue: class, register indices and sign-extended immediate.
- Buffers entries in a small registered FIFO and presents the head to decode with valid/ready; a restart flushes everything.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- XLEN, 64, width of the generated immediate.

Ports:
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; empties the queue.
- restart  in  1  pipeline redirect; flushes the queue in the same cycle.
- fe_valid  in  1  fetch presents an instruction.
- fe_pc  in  `VMSB+1  PC of the presented instruction.
- fe_insn  in  32  instruction word.
- fe_ready  out  1  queue can accept.
- de_valid  out  1  head entry valid.
- de_ready  in  1  decode consumes the head.
- de_pc  out  `VMSB+1  head PC.
- de_insn  out  32  head instruction.
- de_class  out  4  predecoded class code.
- de_rd, de_rs1, de_rs2  out  5 each  register fields (raw bit slices).
- de_imm  out  XLEN  sign-extended immediate for de_class.
- fq_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits (natural wrap) and count of $clog2(DEPTH)+1 bits.
- Reset (priority over everything): count=0, rd_ptr=wr_ptr=0, de_valid=0, fe_ready=1, fq_count=0. Payload outputs are don't-care while de_valid=0.
- fe_ready = (count != DEPTH). There is no pass-through when full, so a push and a pop in the same cycle while full cannot occur.
- de_valid = (count != 0). Payload outputs are read directly from the entry at rd_ptr; no combinational path from fe_* to de_*.
- Push = fe_valid & fe_ready & !restart. Pop = de_valid & de_ready & !restart.
- Latency: an instruction pushed in cycle N appears on de_* in cycle N+1 at the earliest.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Restart (and not reset):
  - next count=0 and rd_ptr=wr_ptr.
  - Any fe_valid in that cycle is dropped.
  - de_ready in that cycle has no effect.
  - Next cycle de_valid=0 and fe_ready=1.
- Order: FIFO order is strict; entries are never reordered or duplicated.
- Predecode is combinational on fe_insn and stored with the entry. Classes, by opcode fe_insn[6:0]:
  - LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111.
  - OP_IMM 0010011, OP_IMM32 0011011, OP 0110011, OP32 0111011.
  - LUI 0110111, AUIPC 0010111, MISC_MEM 0001111, SYSTEM 1110011.
  - Anything else, including insn[1:0] != 2'b11, is ILLEGAL.
- Immediate rules:
  - I-type (LOAD, JALR, OP_IMM*, SYSTEM): sext(insn[31:20]).
  - S: sext({insn[31:25], insn[11:7]}).
  - B: sext({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}).
  - U: sext({insn[31:12], 12'b0}).
  - J: sext({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}).
  - OP, OP32, MISC_MEM, ILLEGAL: 0.
- rd, rs1, rs2 are always the raw fields insn[11:7], [19:15], [24:20], whatever the class.

Decomposition:
- Class codes (4-bit `define constants FQ_CLASS_*) go in the shared yarvi.h alongside `VMSB.
- One combinational sub-module, yarvi_predecode:
  - inputs: insn.
  - outputs: class, rd, rs1, rs2, imm.
  - decode also reuses it for checking.
- The FIFO control stays inline in yarvi_fq.

Test Plan:
- Reset, then push pc=0x1000, insn=0x00500093 with de_ready=0 -> next cycle de_valid=1, de_class=OP_IMM, rd=1, rs1=0, de_imm=5, fq_count=1.
- Push 0xFFF00113 -> de_imm=0xFFFF_FFFF_FFFF_FFFF, rd=2. Push 0x00112423 -> STORE, rs1=2, rs2=1, imm=8. Push 0xFE000EE3 -> BRANCH, imm=-4. Push 0x123452B7 -> LUI, rd=5, imm=0x12345000. Push 0x00000000 -> ILLEGAL, imm=0.
- Hold de_ready=0 and push 5 instructions -> fe_ready=0 after the 4th; the 5th is held until one pop; pops return pcs 0x1000, 0x1004, ... in order, wrapping the pointers twice without loss.
- Full queue, assert restart together with fe_valid=1 and de_ready=1 -> next cycle fq_count=0, de_valid=0, fe_ready=1; the dropped instruction never appears.
- Steady state with fe_valid=1, de_ready=1 every cycle -> fq_count stays 1, one instruction per cycle, head pc advances by 4 each cycle.
- Assert reset with 3 entries queued while restart=1 -> next cycle empty, pointers 0; a following push lands in entry 0.

Source files
------------

// File: rtl/yarvi_fq_pkg.sv
// Shared fetch-queue definitions: address MSB, predecode classes, opcodes.
// Imported by yarvi_predecode, yarvi_fq and decode.
package yarvi_fq_pkg;

  localparam int VMSB = 63;

  typedef enum logic [3:0] {
    FQ_CLASS_ILLEGAL  = 4'd0,
    FQ_CLASS_LOAD     = 4'd1,
    FQ_CLASS_STORE    = 4'd2,
    FQ_CLASS_BRANCH   = 4'd3,
    FQ_CLASS_JAL      = 4'd4,
    FQ_CLASS_JALR     = 4'd5,
    FQ_CLASS_OP_IMM   = 4'd6,
    FQ_CLASS_OP_IMM32 = 4'd7,
    FQ_CLASS_OP       = 4'd8,
    FQ_CLASS_OP32     = 4'd9,
    FQ_CLASS_LUI      = 4'd10,
    FQ_CLASS_AUIPC    = 4'd11,
    FQ_CLASS_MISC_MEM = 4'd12,
    FQ_CLASS_SYSTEM   = 4'd13
  } fq_class_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/yarvi_predecode.sv
// Combinational predecode: class, raw register fields, sign-extended imm.
// Ports: insn in; cls, rd, rs1, rs2, imm out.
module yarvi_predecode
  import yarvi_fq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     insn,
  output logic [3:0]      cls,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm
);

  fq_class_e   c;
  logic [31:0] imm32;

  assign rd  = insn[11:7];
  assign rs1 = insn[19:15];
  assign rs2 = insn[24:20];
  assign cls = c;

  // Every listed opcode ends in 2'b11, so compressed encodings
  // fall through to ILLEGAL.
  always_comb begin
    c = FQ_CLASS_ILLEGAL;
    unique case (insn[6:0])
      OPC_LOAD:     c = FQ_CLASS_LOAD;
      OPC_STORE:    c = FQ_CLASS_STORE;
      OPC_BRANCH:   c = FQ_CLASS_BRANCH;
      OPC_JAL:      c = FQ_CLASS_JAL;
      OPC_JALR:     c = FQ_CLASS_JALR;
      OPC_OP_IMM:   c = FQ_CLASS_OP_IMM;
      OPC_OP_IMM32: c = FQ_CLASS_OP_IMM32;
      OPC_OP:       c = FQ_CLASS_OP;
      OPC_OP32:     c = FQ_CLASS_OP32;
      OPC_LUI:      c = FQ_CLASS_LUI;
      OPC_AUIPC:    c = FQ_CLASS_AUIPC;
      OPC_MISC_MEM: c = FQ_CLASS_MISC_MEM;
      OPC_SYSTEM:   c = FQ_CLASS_SYSTEM;
      default:      c = FQ_CLASS_ILLEGAL;
    endcase
  end

  always_comb begin
    imm32 = '0;
    unique case (c)
      FQ_CLASS_LOAD, FQ_CLASS_JALR, FQ_CLASS_OP_IMM,
      FQ_CLASS_OP_IMM32, FQ_CLASS_SYSTEM:
        imm32 = {{20{insn[31]}}, insn[31:20]};
      FQ_CLASS_STORE:
        imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      FQ_CLASS_BRANCH:
        imm32 = {{19{insn[31]}}, insn[31], insn[7],
                 insn[30:25], insn[11:8], 1'b0};
      FQ_CLASS_LUI, FQ_CLASS_AUIPC:
        imm32 = {insn[31:12], 12'b0};
      FQ_CLASS_JAL:
        imm32 = {{11{insn[31]}}, insn[31], insn[19:12],
                 insn[20], insn[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/yarvi_fq.sv
// Fetch queue: registered circular FIFO of predecoded fetch packets.
// Ports: clock/reset/restart, fe_* enqueue side, de_* head side, fq_count.
module yarvi_fq
  import yarvi_fq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   restart,
  input  logic                   fe_valid,
  input  logic [VMSB:0]          fe_pc,
  input  logic [31:0]            fe_insn,
  output logic                   fe_ready,
  output logic                   de_valid,
  input  logic                   de_ready,
  output logic [VMSB:0]          de_pc,
  output logic [31:0]            de_insn,
  output logic [3:0]             de_class,
  output logic [4:0]             de_rd,
  output logic [4:0]             de_rs1,
  output logic [4:0]             de_rs2,
  output logic [XLEN-1:0]        de_imm,
  output logic [$clog2(DEPTH):0] fq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [VMSB:0]   pc_q   [DEPTH];
  logic [31:0]     insn_q [DEPTH];
  logic [3:0]      cls_q  [DEPTH];
  logic [4:0]      rd_q   [DEPTH];
  logic [4:0]      rs1_q  [DEPTH];
  logic [4:0]      rs2_q  [DEPTH];
  logic [XLEN-1:0] imm_q  [DEPTH];

  logic [3:0]      pd_cls;
  logic [4:0]      pd_rd, pd_rs1, pd_rs2;
  logic [XLEN-1:0] pd_imm;

  logic push, pop;

  yarvi_predecode #(.XLEN(XLEN)) u_pd (
    .insn (fe_insn),
    .cls  (pd_cls),
    .rd   (pd_rd),
    .rs1  (pd_rs1),
    .rs2  (pd_rs2),
    .imm  (pd_imm)
  );

  // No pass-through when full: fe_ready depends only on count.
  assign fe_ready = (count_q != CW'(DEPTH));
  assign de_valid = (count_q != '0);
  assign fq_count = count_q;

  assign push = fe_valid & fe_ready & ~restart;
  assign pop  = de_valid & de_ready & ~restart;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (restart) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)
        count_d = count_q + CW'(1);
      else if (pop && !push)
        count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; it is only visible while de_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[wr_ptr_q]   <= fe_pc;
      insn_q[wr_ptr_q] <= fe_insn;
      cls_q[wr_ptr_q]  <= pd_cls;
      rd_q[wr_ptr_q]   <= pd_rd;
      rs1_q[wr_ptr_q]  <= pd_rs1;
      rs2_q[wr_ptr_q]  <= pd_rs2;
      imm_q[wr_ptr_q]  <= pd_imm;
    end
  end

  assign de_pc    = pc_q[rd_ptr_q];
  assign de_insn  = insn_q[rd_ptr_q];
  assign de_class = cls_q[rd_ptr_q];
  assign de_rd    = rd_q[rd_ptr_q];
  assign de_rs1   = rs1_q[rd_ptr_q];
  assign de_rs2   = rs2_q[rd_ptr_q];
  assign de_imm   = imm_q[rd_ptr_q];

endmodule

// File: tb/tb_yarvi_fq.sv
// Bench for yarvi_fq: predecode vector table plus FIFO scoreboard.
// Drives and samples on the falling clock edge.
module tb_yarvi_fq;
  import yarvi_fq_pkg::*;

  logic        clock = 1'b0;
  logic        reset, restart, fe_valid, de_ready;
  logic [63:0] fe_pc;
  logic [31:0] fe_insn;
  logic        fe_ready, de_valid;
  logic [63:0] de_pc;
  logic [31:0] de_insn;
  logic [3:0]  de_class;
  logic [4:0]  de_rd, de_rs1, de_rs2;
  logic [63:0] de_imm;
  logic [2:0]  fq_count;

  always #5 clock = ~clock;

  yarvi_fq #(.DEPTH(4), .XLEN(64)) dut (
    .clock(clock), .reset(reset), .restart(restart),
    .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_insn(fe_insn),
    .fe_ready(fe_ready), .de_valid(de_valid), .de_ready(de_ready),
    .de_pc(de_pc), .de_insn(de_insn), .de_class(de_class),
    .de_rd(de_rd), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_imm(de_imm), .fq_count(fq_count)
  );

  typedef struct {
    logic [31:0] insn;
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    vec_t        v;
  } exp_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  exp_t sb [$];
  vec_t cur;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: account for the handshake implied by the current inputs,
  // then advance to the next falling edge.
  task automatic cycle();
    bit   psh, pp;
    exp_t e;
    psh = fe_valid && fe_ready && !restart && !reset;
    pp  = de_valid && de_ready && !restart && !reset;
    if (pp) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", de_pc, 64'hx);
      end else begin
        e = sb.pop_front();
        chk("pc",    de_pc,    e.pc);
        chk("insn",  64'(de_insn),  64'(e.v.insn));
        chk("class", 64'(de_class), 64'(e.v.cls));
        chk("rd",    64'(de_rd),    64'(e.v.rd));
        chk("rs1",   64'(de_rs1),   64'(e.v.rs1));
        chk("rs2",   64'(de_rs2),   64'(e.v.rs2));
        chk("imm",   de_imm,   e.v.imm);
      end
    end
    if (reset || restart) sb.delete();
    else if (psh) begin
      e.pc = fe_pc;
      e.v  = cur;
      sb.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic drive(logic [63:0] pc, int idx);
    fe_valid = 1'b1;
    fe_pc    = pc;
    cur      = vecs[idx];
    fe_insn  = cur.insn;
  endtask

  task automatic drain();
    fe_valid = 1'b0;
    de_ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) cycle();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_valid", 64'(de_valid), 64'd0);
    de_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, FQ_CLASS_OP_IMM,  5'd1,  5'd0,  5'd5,
                 64'd5};
    vecs[1]  = '{32'hFFF00113, FQ_CLASS_OP_IMM,  5'd2,  5'd0,  5'd31,
                 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{32'h00112423, FQ_CLASS_STORE,   5'd8,  5'd2,  5'd1,
                 64'd8};
    vecs[3]  = '{32'hFE000EE3, FQ_CLASS_BRANCH,  5'd29, 5'd0,  5'd0,
                 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[4]  = '{32'h123452B7, FQ_CLASS_LUI,     5'd5,  5'd8,  5'd3,
                 64'h0000_0000_1234_5000};
    vecs[5]  = '{32'h00000000, FQ_CLASS_ILLEGAL, 5'd0,  5'd0,  5'd0,
                 64'd0};
    vecs[6]  = '{32'h008000EF, FQ_CLASS_JAL,     5'd1,  5'd0,  5'd8,
                 64'd8};
    vecs[7]  = '{32'hFFFFF517, FQ_CLASS_AUIPC,   5'd10, 5'd31, 5'd31,
                 64'hFFFF_FFFF_FFFF_F000};
    vecs[8]  = '{32'h000080E7, FQ_CLASS_JALR,    5'd1,  5'd1,  5'd0,
                 64'd0};
    vecs[9]  = '{32'h002081B3, FQ_CLASS_OP,      5'd3,  5'd1,  5'd2,
                 64'd0};
    vecs[10] = '{32'h00000073, FQ_CLASS_SYSTEM,  5'd0,  5'd0,  5'd0,
                 64'd0};
    vecs[11] = '{32'h00000001, FQ_CLASS_ILLEGAL, 5'd0,  5'd0,  5'd0,
                 64'd0};
    vecs[12] = '{32'hFF843503, FQ_CLASS_LOAD,    5'd10, 5'd8,  5'd24,
                 64'hFFFF_FFFF_FFFF_FFF8};

    reset = 1'b1; restart = 1'b0; fe_valid = 1'b0; de_ready = 1'b0;
    fe_pc = '0; fe_insn = '0; cur = vecs[5];
    @(negedge clock);
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_valid", 64'(de_valid), 64'd0);
    chk("rst_ready", 64'(fe_ready), 64'd1);
    chk("rst_count", 64'(fq_count), 64'd0);

    // Predecode table: push with de_ready low, then pop next cycle.
    for (int i = 0; i < NV; i++) begin
      drive(64'h1000 + 64'(4 * i), i);
      cycle();
      fe_valid = 1'b0;
      chk("tbl_valid", 64'(de_valid), 64'd1);
      chk("tbl_count", 64'(fq_count), 64'd1);
      de_ready = 1'b1;
      cycle();
      de_ready = 1'b0;
    end
    chk("tbl_empty", 64'(de_valid), 64'd0);

    // Fill to full; fifth instruction waits for one pop.
    for (int i = 0; i < 4; i++) begin
      drive(64'h2000 + 64'(4 * i), i);
      cycle();
    end
    drive(64'h2010, 4);
    chk("full_ready", 64'(fe_ready), 64'd0);
    chk("full_count", 64'(fq_count), 64'd4);
    cycle();
    cycle();
    chk("full_hold", 64'(fq_count), 64'd4);
    de_ready = 1'b1;
    cycle();
    de_ready = 1'b0;
    chk("after_pop", 64'(fq_count), 64'd3);
    chk("after_pop_rdy", 64'(fe_ready), 64'd1);
    cycle();
    fe_valid = 1'b0;
    chk("refill", 64'(fq_count), 64'd4);
    drain();

    // Two more full rounds to wrap pointers.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        drive(64'h2100 + 64'(16 * r + 4 * i), 6 + i);
        cycle();
      end
      fe_valid = 1'b0;
      chk("wrap_count", 64'(fq_count), 64'd4);
      drain();
    end

    // Restart while full with push and pop requested.
    for (int i = 0; i < 4; i++) begin
      drive(64'h3000 + 64'(4 * i), i);
      cycle();
    end
    drive(64'h3100, 5);
    de_ready = 1'b1;
    restart  = 1'b1;
    cycle();
    restart  = 1'b0;
    fe_valid = 1'b0;
    de_ready = 1'b0;
    chk("rs_count", 64'(fq_count), 64'd0);
    chk("rs_valid", 64'(de_valid), 64'd0);
    chk("rs_ready", 64'(fe_ready), 64'd1);
    drive(64'h3200, 6);
    cycle();
    fe_valid = 1'b0;
    chk("rs_next", 64'(fq_count), 64'd1);
    drain();

    // Streaming: one in, one out every cycle.
    drive(64'h4000, 0);
    cycle();
    de_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(64'h4004 + 64'(4 * k), (k + 1) % NV);
      cycle();
      chk("steady_count", 64'(fq_count), 64'd1);
    end
    drain();

    // Reset overrides restart with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(64'h5000 + 64'(4 * i), i);
      cycle();
    end
    fe_valid = 1'b0;
    reset    = 1'b1;
    restart  = 1'b1;
    cycle();
    reset    = 1'b0;
    restart  = 1'b0;
    chk("rr_count", 64'(fq_count), 64'd0);
    chk("rr_valid", 64'(de_valid), 64'd0);
    chk("rr_ready", 64'(fe_ready), 64'd1);
    chk("rr_rdptr", 64'(dut.rd_ptr_q), 64'd0);
    chk("rr_wrptr", 64'(dut.wr_ptr_q), 64'd0);
    drive(64'h6000, 12);
    cycle();
    fe_valid = 1'b0;
    chk("rr_entry0", dut.pc_q[0], 64'h6000);
    chk("rr_wrptr1", 64'(dut.wr_ptr_q), 64'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
